// File: rtl/ap_ctrl_driver.sv
// Sequences a run of cfg_num_txn transactions over an ap_start/ap_ready/ap_done/ap_continue kernel
// handshake, measuring per-transaction latency and aborting on timeout or cfg_abort.
module ap_ctrl_driver #(
    parameter int CNT_W   = 16,
    parameter int LAT_W   = 32,
    parameter int TIMEOUT = 100000
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             cfg_go,
    input  logic [CNT_W-1:0] cfg_num_txn,
    input  logic             cfg_abort,
    output logic             ap_start,
    input  logic             ap_ready,
    input  logic             ap_done,
    output logic             ap_continue,
    output logic             finish,
    output logic             busy,
    output logic             err_timeout,
    output logic [CNT_W-1:0] txn_done,
    output logic [LAT_W-1:0] last_lat,
    output logic [LAT_W-1:0] max_lat
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_WAIT_DONE = 3'd2,
        S_ACK       = 3'd3,
        S_FINISH    = 3'd4
    } state_t;

    localparam logic [LAT_W-1:0] TIMEOUT_VAL = LAT_W'(TIMEOUT);

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_num_txn;
    logic [CNT_W-1:0]   r_txn_done;
    logic [LAT_W-1:0]   r_lat;
    logic [LAT_W-1:0]   r_last_lat;
    logic [LAT_W-1:0]   r_max_lat;
    logic               r_err;
    logic               r_abort_pend;

    logic               w_go_acc;
    logic               w_in_run;
    logic               w_done_hit;
    logic               w_timeout_hit;
    logic               w_more;
    logic               w_enter_start;
    logic [LAT_W-1:0]   w_lat_inc;

    // Latency this cycle included; saturates rather than wrapping
    assign w_lat_inc     = (&r_lat) ? r_lat : r_lat + LAT_W'(1);
    assign w_go_acc      = cfg_go && ((r_state == S_IDLE) || (r_state == S_FINISH));
    assign w_in_run      = (r_state == S_START) || (r_state == S_WAIT_DONE);
    assign w_done_hit    = ((r_state == S_START) && ap_ready && ap_done) ||
                           ((r_state == S_WAIT_DONE) && ap_done);
    // A completed transaction or an abort takes precedence over the timeout
    assign w_timeout_hit = w_in_run && !w_done_hit && !cfg_abort && (w_lat_inc >= TIMEOUT_VAL);
    assign w_more        = ((CNT_W+1)'(r_txn_done) + (CNT_W+1)'(1)) < (CNT_W+1)'(r_num_txn);
    assign w_enter_start = (w_next == S_START) && (r_state != S_START);

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_FINISH: begin
                if (cfg_go) begin
                    w_next = (cfg_num_txn == '0) ? S_FINISH : S_START;
                end
            end
            S_START: begin
                if (w_done_hit) begin
                    w_next = S_ACK;
                end else if (cfg_abort || w_timeout_hit) begin
                    w_next = S_FINISH;
                end else if (ap_ready) begin
                    w_next = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (w_done_hit) begin
                    w_next = S_ACK;
                end else if (cfg_abort || w_timeout_hit) begin
                    w_next = S_FINISH;
                end
            end
            S_ACK: begin
                if (cfg_abort || r_abort_pend || !w_more) begin
                    w_next = S_FINISH;
                end else begin
                    w_next = S_START;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_num_txn    <= '0;
            r_txn_done   <= '0;
            r_lat        <= '0;
            r_last_lat   <= '0;
            r_max_lat    <= '0;
            r_err        <= 1'b0;
            r_abort_pend <= 1'b0;
        end else begin
            if (w_go_acc) begin
                r_num_txn    <= cfg_num_txn;
                r_txn_done   <= '0;
                r_last_lat   <= '0;
                r_max_lat    <= '0;
                r_err        <= 1'b0;
                r_abort_pend <= 1'b0;
            end
            if (w_enter_start) begin
                r_lat <= '0;
            end else if (w_in_run) begin
                r_lat <= w_lat_inc;
            end
            // Abort arriving together with done: acknowledge first, then finish
            if (w_done_hit && cfg_abort) begin
                r_abort_pend <= 1'b1;
            end
            if (w_timeout_hit) begin
                r_err <= 1'b1;
            end
            if (r_state == S_ACK) begin
                r_txn_done   <= r_txn_done + CNT_W'(1);
                r_last_lat   <= r_lat;
                r_abort_pend <= 1'b0;
                if (r_lat > r_max_lat) begin
                    r_max_lat <= r_lat;
                end
            end
        end
    end

    assign ap_start    = (r_state == S_START);
    assign ap_continue = (r_state == S_ACK);
    assign finish      = (r_state == S_FINISH);
    assign busy        = (r_state == S_START) || (r_state == S_WAIT_DONE) || (r_state == S_ACK);
    assign err_timeout = r_err;
    assign txn_done    = r_txn_done;
    assign last_lat    = r_last_lat;
    assign max_lat     = r_max_lat;

endmodule

// File: tb/tb_ap_ctrl_driver.sv
// Randomized kernel-handshake bench for ap_ctrl_driver; expected counts and latencies come
// from the per-transaction ready/done delays the bench itself chose.
module tb_ap_ctrl_driver;

    localparam int CNT_W = 16;
    localparam int LAT_W = 32;
    localparam int TMO   = 20;

    logic             ap_clk = 1'b0;
    logic             ap_rst_n = 1'b0;
    logic             cfg_go = 1'b0;
    logic [CNT_W-1:0] cfg_num_txn = '0;
    logic             cfg_abort = 1'b0;
    logic             ap_start;
    logic             ap_ready = 1'b0;
    logic             ap_done = 1'b0;
    logic             ap_continue;
    logic             finish;
    logic             busy;
    logic             err_timeout;
    logic [CNT_W-1:0] txn_done;
    logic [LAT_W-1:0] last_lat;
    logic [LAT_W-1:0] max_lat;

    int n_vec = 0;
    int n_err = 0;
    int rd_q[16];
    int dd_q[16];

    ap_ctrl_driver #(.CNT_W(CNT_W), .LAT_W(LAT_W), .TIMEOUT(TMO)) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .cfg_go(cfg_go), .cfg_num_txn(cfg_num_txn),
        .cfg_abort(cfg_abort), .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done),
        .ap_continue(ap_continue), .finish(finish), .busy(busy), .err_timeout(err_timeout),
        .txn_done(txn_done), .last_lat(last_lat), .max_lat(max_lat)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Kernel behaviour: accept start in START cycle rd (>=1), return done dd cycles later
    task automatic do_txn(input int rd, input int dd);
        int t;
        t = 0;
        while (!ap_start && t < 50) begin
            @(negedge ap_clk);
            t++;
        end
        check_eq("start_seen", ap_start, 1);
        repeat (rd - 1) @(negedge ap_clk);
        check_eq("start_held", ap_start, 1);
        ap_ready = 1'b1;
        ap_done  = (dd == 0);
        @(negedge ap_clk);
        ap_ready = 1'b0;
        ap_done  = 1'b0;
        if (dd > 0) begin
            check_eq("start_dropped", ap_start, 0);
            repeat (dd - 1) @(negedge ap_clk);
            ap_done = 1'b1;
            @(negedge ap_clk);
            ap_done = 1'b0;
        end
        check_eq("ack", ap_continue, 1);
        @(negedge ap_clk);
        check_eq("ack_one_cycle", ap_continue, 0);
    endtask

    task automatic launch(input int n);
        cfg_num_txn = CNT_W'(n);
        cfg_go = 1'b1;
        @(negedge ap_clk);
        cfg_go = 1'b0;
    endtask

    task automatic do_run(input int n);
        int lat;
        int mx;
        lat = 0;
        mx  = 0;
        launch(n);
        check_eq("go_finish_clr", finish, 0);
        check_eq("go_txn_clr", txn_done, 0);
        check_eq("go_last_clr", last_lat, 0);
        check_eq("go_max_clr", max_lat, 0);
        check_eq("go_err_clr", err_timeout, 0);
        check_eq("go_busy", busy, 1);
        for (int i = 0; i < n; i++) begin
            do_txn(rd_q[i], dd_q[i]);
            lat = rd_q[i] + dd_q[i];
            if (lat > mx) mx = lat;
        end
        check_eq("run_finish", finish, 1);
        check_eq("run_busy", busy, 0);
        check_eq("run_start", ap_start, 0);
        check_eq("run_txn_done", txn_done, n);
        check_eq("run_last_lat", last_lat, lat);
        check_eq("run_max_lat", max_lat, mx);
        check_eq("run_err", err_timeout, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int cnt;
        int cont;
        int n;

        repeat (3) @(negedge ap_clk);
        check_eq("rst_start", ap_start, 0);
        check_eq("rst_cont", ap_continue, 0);
        check_eq("rst_finish", finish, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_err", err_timeout, 0);
        check_eq("rst_txn", txn_done, 0);
        check_eq("rst_last", last_lat, 0);
        check_eq("rst_max", max_lat, 0);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);

        // Zero-length run from IDLE
        launch(0);
        check_eq("zero_finish", finish, 1);
        check_eq("zero_start", ap_start, 0);
        check_eq("zero_busy", busy, 0);
        check_eq("zero_txn", txn_done, 0);

        // Three transactions, ready after 2 cycles, done 5 cycles later (latency 7)
        for (int i = 0; i < 3; i++) begin rd_q[i] = 2; dd_q[i] = 5; end
        do_run(3);

        // Ready and done in the very first START cycle (latency 1)
        for (int i = 0; i < 2; i++) begin rd_q[i] = 1; dd_q[i] = 0; end
        do_run(2);

        // Kernel never answers: timeout after TMO cycles of latency
        launch(1);
        cnt = 0;
        cont = 0;
        while (ap_start && cnt < 100) begin
            cnt++;
            @(negedge ap_clk);
            if (ap_continue) cont++;
        end
        check_eq("tmo_cycles", cnt, TMO);
        check_eq("tmo_err", err_timeout, 1);
        check_eq("tmo_finish", finish, 1);
        check_eq("tmo_start", ap_start, 0);
        check_eq("tmo_txn", txn_done, 0);
        check_eq("tmo_cont", cont, 0);

        // Abort in WAIT_DONE of transaction 2 of 5
        launch(5);
        do_txn(2, 3);
        ap_ready = 1'b1;
        @(negedge ap_clk);
        ap_ready = 1'b0;
        check_eq("abort_wait", ap_start, 0);
        @(negedge ap_clk);
        cfg_abort = 1'b1;
        @(negedge ap_clk);
        cfg_abort = 1'b0;
        check_eq("abort_finish", finish, 1);
        check_eq("abort_busy", busy, 0);
        check_eq("abort_cont", ap_continue, 0);
        check_eq("abort_txn", txn_done, 1);
        check_eq("abort_last", last_lat, 5);

        // Abort coinciding with done: acknowledged and counted, then finish
        launch(3);
        do_txn(1, 2);
        ap_ready = 1'b1;
        @(negedge ap_clk);
        ap_ready = 1'b0;
        ap_done = 1'b1;
        cfg_abort = 1'b1;
        @(negedge ap_clk);
        ap_done = 1'b0;
        cfg_abort = 1'b0;
        check_eq("abdone_ack", ap_continue, 1);
        @(negedge ap_clk);
        check_eq("abdone_finish", finish, 1);
        check_eq("abdone_txn", txn_done, 2);
        check_eq("abdone_last", last_lat, 2);
        check_eq("abdone_max", max_lat, 3);

        // Randomized runs
        for (int r = 0; r < 10; r++) begin
            n = $urandom_range(1, 5);
            for (int i = 0; i < n; i++) begin
                rd_q[i] = $urandom_range(1, 4);
                dd_q[i] = $urandom_range(0, 6);
            end
            do_run(n);
        end

        // Reset in the middle of START, then a spurious done while IDLE
        launch(2);
        check_eq("mid_start", ap_start, 1);
        #2 ap_rst_n = 1'b0;
        #1;
        check_eq("arst_start", ap_start, 0);
        check_eq("arst_busy", busy, 0);
        check_eq("arst_finish", finish, 0);
        check_eq("arst_txn", txn_done, 0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        ap_done = 1'b1;
        @(negedge ap_clk);
        ap_done = 1'b0;
        check_eq("idle_done_cont", ap_continue, 0);
        check_eq("idle_done_busy", busy, 0);
        check_eq("idle_done_finish", finish, 0);
        @(negedge ap_clk);
        check_eq("idle_done_cont2", ap_continue, 0);
        check_eq("idle_done_txn", txn_done, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
